// File: rtl/fp_issue_arbiter.sv
// Round-robin issue arbiter for the shared FP pipeline, with multi-subcycle sequencing and an in-flight tracker.
// Optional build macro FP_ISSUE_ARB_PERF_EN adds the perf_contention counter output.
module fp_issue_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int FP_LATENCY     = 5,
    parameter int INT_LATENCY    = 1,
    parameter int NUM_SUBCYCLES  = 4,
    localparam int IDXW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1,
    localparam int SUBW = (NUM_SUBCYCLES > 1) ? $clog2(NUM_SUBCYCLES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] req_valid,
    input  logic [NUM_REQUESTERS-1:0] req_multi_cycle,
    input  logic                      rollback_en,
    input  logic [IDXW-1:0]           rollback_idx,
    output logic [NUM_REQUESTERS-1:0] grant_oh,
    output logic                      fx_issue_valid,
    output logic [IDXW-1:0]           fx_issue_idx,
    output logic [SUBW-1:0]           fx_issue_subcycle,
    output logic [NUM_REQUESTERS-1:0] fx_inflight,
    output logic                      fp_wb_valid,
    output logic [IDXW-1:0]           fp_wb_idx,
    output logic                      int_issue_block
`ifdef FP_ISSUE_ARB_PERF_EN
    ,
    output logic [31:0]               perf_contention
`endif
);

    typedef enum logic {IDLE, SEQUENCE} state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQUESTERS - 1);
    localparam logic [SUBW-1:0] LAST_SUB = SUBW'(NUM_SUBCYCLES - 1);
    localparam bit              MULTI_EN = (NUM_SUBCYCLES > 1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [SUBW-1:0] subcycle_q, subcycle_d;

    logic            stage_valid_q [1:FP_LATENCY];
    logic            stage_valid_d [1:FP_LATENCY];
    logic [IDXW-1:0] stage_idx_q   [1:FP_LATENCY];
    logic [IDXW-1:0] stage_idx_d   [1:FP_LATENCY];
    logic            stage_live    [1:FP_LATENCY];

    logic [NUM_REQUESTERS-1:0] eligible;
    logic                      scan_found;
    logic [IDXW-1:0]           scan_idx;
    logic [IDXW-1:0]           cand_idx;
    int                        cand;
    logic                      owner_rollback;

    function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] x);
        return (x == LAST_IDX) ? '0 : x + IDXW'(1);
    endfunction

    always_comb begin
        eligible = '0;
        for (int r = 0; r < NUM_REQUESTERS; r++) begin
            eligible[r] = req_valid[r] && !(rollback_en && (rollback_idx == IDXW'(r)));
        end
    end

    // First eligible requester at or after rr_ptr, wrapping around.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_REQUESTERS) begin
                cand = cand - NUM_REQUESTERS;
            end
            cand_idx = IDXW'(cand);
            if (!scan_found && eligible[cand_idx]) begin
                scan_found = 1'b1;
                scan_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        owner_rollback    = rollback_en && (rollback_idx == owner_q);
        fx_issue_valid    = 1'b0;
        fx_issue_idx      = '0;
        fx_issue_subcycle = '0;
        if (!reset) begin
            if (state_q == SEQUENCE) begin
                fx_issue_valid    = !owner_rollback;
                fx_issue_idx      = owner_q;
                fx_issue_subcycle = subcycle_q;
            end else begin
                fx_issue_valid    = scan_found;
                fx_issue_idx      = scan_idx;
            end
        end
        grant_oh = '0;
        if (fx_issue_valid) begin
            grant_oh[fx_issue_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        subcycle_d = subcycle_q;
        case (state_q)
            IDLE: begin
                if (scan_found) begin
                    if (MULTI_EN && req_multi_cycle[scan_idx]) begin
                        owner_d    = scan_idx;
                        subcycle_d = SUBW'(1);
                        state_d    = SEQUENCE;
                    end else begin
                        rr_ptr_d = wrap_inc(scan_idx);
                    end
                end
            end
            SEQUENCE: begin
                if (owner_rollback || (subcycle_q == LAST_SUB)) begin
                    state_d    = IDLE;
                    subcycle_d = '0;
                    rr_ptr_d   = wrap_inc(owner_q);
                end else begin
                    subcycle_d = subcycle_q + SUBW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A stage is live unless its thread is being rolled back this cycle; squashed entries do not advance.
    always_comb begin
        for (int k = 1; k <= FP_LATENCY; k++) begin
            stage_live[k] = stage_valid_q[k] && !(rollback_en && (rollback_idx == stage_idx_q[k]));
        end
        stage_valid_d[1] = fx_issue_valid;
        stage_idx_d[1]   = fx_issue_idx;
        for (int k = 2; k <= FP_LATENCY; k++) begin
            stage_valid_d[k] = stage_live[k-1];
            stage_idx_d[k]   = stage_idx_q[k-1];
        end
    end

    always_comb begin
        fx_inflight = '0;
        for (int k = 1; k <= FP_LATENCY; k++) begin
            if (stage_live[k]) begin
                fx_inflight[stage_idx_q[k]] = 1'b1;
            end
        end
    end

    assign fp_wb_valid     = stage_live[FP_LATENCY];
    assign fp_wb_idx       = stage_idx_q[FP_LATENCY];
    assign int_issue_block = stage_live[FP_LATENCY-INT_LATENCY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            subcycle_q <= '0;
            for (int k = 1; k <= FP_LATENCY; k++) begin
                stage_valid_q[k] <= 1'b0;
                stage_idx_q[k]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            subcycle_q <= subcycle_d;
            for (int k = 1; k <= FP_LATENCY; k++) begin
                stage_valid_q[k] <= stage_valid_d[k];
                stage_idx_q[k]   <= stage_idx_d[k];
            end
        end
    end

`ifdef FP_ISSUE_ARB_PERF_EN
    // Counts cycles where some eligible thread was left waiting.
    logic [31:0] perf_contention_q, perf_contention_d;

    assign perf_contention_d = perf_contention_q + ((|(eligible & ~grant_oh)) ? 32'd1 : 32'd0);
    assign perf_contention   = perf_contention_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_contention_q <= '0;
        end else begin
            perf_contention_q <= perf_contention_d;
        end
    end
`endif

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Self-checking bench for fp_issue_arbiter: directed vector table, hand-written multi-cycle sequences,
// and randomized traffic against a queue-based reference model.
module tb_fp_issue_arbiter;

    localparam int N    = 4;
    localparam int LAT  = 5;
    localparam int ILAT = 1;
    localparam int NSUB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_valid = '0;
    logic [3:0] req_multi_cycle = '0;
    logic       rollback_en = 1'b0;
    logic [1:0] rollback_idx = '0;
    logic [3:0] grant_oh;
    logic       fx_issue_valid;
    logic [1:0] fx_issue_idx;
    logic [1:0] fx_issue_subcycle;
    logic [3:0] fx_inflight;
    logic       fp_wb_valid;
    logic [1:0] fp_wb_idx;
    logic       int_issue_block;
`ifdef FP_ISSUE_ARB_PERF_EN
    logic [31:0] perf_contention;
`endif

    fp_issue_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_multi_cycle   (req_multi_cycle),
        .rollback_en       (rollback_en),
        .rollback_idx      (rollback_idx),
        .grant_oh          (grant_oh),
        .fx_issue_valid    (fx_issue_valid),
        .fx_issue_idx      (fx_issue_idx),
        .fx_issue_subcycle (fx_issue_subcycle),
        .fx_inflight       (fx_inflight),
        .fp_wb_valid       (fp_wb_valid),
        .fp_wb_idx         (fp_wb_idx),
        .int_issue_block   (int_issue_block)
`ifdef FP_ISSUE_ARB_PERF_EN
        ,
        .perf_contention   (perf_contention)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] multi;
        logic       rb_en;
        logic [1:0] rb_idx;
        logic [3:0] grant;
        logic       valid;
        logic [1:0] idx;
        logic [1:0] sub;
        logic [3:0] infl;
        logic       wb;
        logic [1:0] wb_idx;
        logic       block;
    } vec_t;

    typedef struct {
        int thr;
        int age;
    } op_t;

    vec_t vecs [27];

    function automatic vec_t mkVec(input logic [3:0] req, input logic [3:0] multi, input logic rb_en,
                                   input logic [1:0] rb_idx, input logic [3:0] grant, input logic valid,
                                   input logic [1:0] idx, input logic [1:0] sub, input logic [3:0] infl,
                                   input logic wb, input logic [1:0] wb_idx, input logic block);
        vec_t v;
        v.req = req; v.multi = multi; v.rb_en = rb_en; v.rb_idx = rb_idx;
        v.grant = grant; v.valid = valid; v.idx = idx; v.sub = sub;
        v.infl = infl; v.wb = wb; v.wb_idx = wb_idx; v.block = block;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] multi,
                                 input logic rb_en, input logic [1:0] rb_idx);
        req_valid       = req;
        req_multi_cycle = multi;
        rollback_en     = rb_en;
        rollback_idx    = rb_idx;
    endtask

    task automatic expectOutputs(input string tag, input vec_t v);
        checkOutput({tag, " grant_oh"}, 32'(grant_oh), 32'(v.grant));
        checkOutput({tag, " issue_valid"}, 32'(fx_issue_valid), 32'(v.valid));
        if (v.valid) begin
            checkOutput({tag, " issue_idx"}, 32'(fx_issue_idx), 32'(v.idx));
            checkOutput({tag, " issue_sub"}, 32'(fx_issue_subcycle), 32'(v.sub));
        end
        checkOutput({tag, " inflight"}, 32'(fx_inflight), 32'(v.infl));
        checkOutput({tag, " wb_valid"}, 32'(fp_wb_valid), 32'(v.wb));
        if (v.wb) begin
            checkOutput({tag, " wb_idx"}, 32'(fp_wb_idx), 32'(v.wb_idx));
        end
        checkOutput({tag, " int_block"}, 32'(int_issue_block), 32'(v.block));
    endtask

    task automatic runStep(input string tag, input vec_t v);
        @(negedge clk);
        applyStimulus(v.req, v.multi, v.rb_en, v.rb_idx);
        #1;
        expectOutputs(tag, v);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 2'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic randomPhase(input int ncycles);
        op_t        ops[$];
        op_t        nxt[$];
        op_t        o;
        int         m_rr;
        int         m_owner;
        int         m_sub;
        int         exp_thr;
        int         exp_sub;
        int         exp_wb;
        int         t;
        logic       exp_blk;
        logic [3:0] exp_infl;
        logic [3:0] r;
        logic [3:0] mc;
        logic       rbe;
        logic [1:0] rbi;
        doReset();
        m_rr = 0;
        m_owner = -1;
        m_sub = 0;
        for (int cyc = 0; cyc < ncycles; cyc++) begin
            @(negedge clk);
            r   = 4'($urandom);
            mc  = 4'($urandom & $urandom);
            rbe = ($urandom_range(0, 7) == 0);
            rbi = 2'($urandom_range(0, 3));
            applyStimulus(r, mc, rbe, rbi);
            #1;
            exp_thr = -1;
            exp_sub = 0;
            if (m_owner >= 0) begin
                if (!(rbe && int'(rbi) == m_owner)) begin
                    exp_thr = m_owner;
                    exp_sub = m_sub;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    t = (m_rr + i) % N;
                    if (exp_thr < 0 && r[t] && !(rbe && int'(rbi) == t)) exp_thr = t;
                end
            end
            exp_infl = '0;
            exp_wb = -1;
            exp_blk = 1'b0;
            foreach (ops[j]) begin
                if (!(rbe && int'(rbi) == ops[j].thr)) begin
                    exp_infl[ops[j].thr] = 1'b1;
                    if (ops[j].age == LAT) exp_wb = ops[j].thr;
                    if (ops[j].age == LAT - ILAT) exp_blk = 1'b1;
                end
            end
            checkOutput("rand grant_oh", 32'(grant_oh), (exp_thr >= 0) ? (32'd1 << exp_thr) : 32'd0);
            checkOutput("rand issue_valid", 32'(fx_issue_valid), (exp_thr >= 0) ? 32'd1 : 32'd0);
            if (exp_thr >= 0) begin
                checkOutput("rand issue_idx", 32'(fx_issue_idx), exp_thr);
                checkOutput("rand issue_sub", 32'(fx_issue_subcycle), exp_sub);
            end
            checkOutput("rand inflight", 32'(fx_inflight), 32'(exp_infl));
            checkOutput("rand wb_valid", 32'(fp_wb_valid), (exp_wb >= 0) ? 32'd1 : 32'd0);
            if (exp_wb >= 0) checkOutput("rand wb_idx", 32'(fp_wb_idx), exp_wb);
            checkOutput("rand int_block", 32'(int_issue_block), 32'(exp_blk));
            if (m_owner >= 0) begin
                if (rbe && int'(rbi) == m_owner) begin
                    m_rr = (m_owner + 1) % N;
                    m_owner = -1;
                end else begin
                    m_sub++;
                    if (m_sub == NSUB) begin
                        m_rr = (m_owner + 1) % N;
                        m_owner = -1;
                    end
                end
            end else if (exp_thr >= 0) begin
                if (mc[exp_thr]) begin
                    m_owner = exp_thr;
                    m_sub = 1;
                end else begin
                    m_rr = (exp_thr + 1) % N;
                end
            end
            nxt.delete();
            foreach (ops[j]) begin
                if (!(rbe && int'(rbi) == ops[j].thr) && ops[j].age < LAT) begin
                    o.thr = ops[j].thr;
                    o.age = ops[j].age + 1;
                    nxt.push_back(o);
                end
            end
            if (exp_thr >= 0) begin
                o.thr = exp_thr;
                o.age = 1;
                nxt.push_back(o);
            end
            ops = nxt;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Round-robin alternation, multi-cycle sequence with writebacks, single-issue timing.
        vecs[0]  = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
        vecs[1]  = mkVec(4'b1010, 4'b0000, 0, 0, 4'b0010, 1, 1, 0, 4'b0000, 0, 0, 0);
        vecs[2]  = mkVec(4'b1010, 4'b0000, 0, 0, 4'b1000, 1, 3, 0, 4'b0010, 0, 0, 0);
        vecs[3]  = mkVec(4'b1010, 4'b0000, 0, 0, 4'b0010, 1, 1, 0, 4'b1010, 0, 0, 0);
        vecs[4]  = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b1010, 0, 0, 0);
        vecs[5]  = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b1010, 0, 0, 1);
        vecs[6]  = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b1010, 1, 1, 1);
        vecs[7]  = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b1010, 1, 3, 1);
        vecs[8]  = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0010, 1, 1, 0);
        vecs[9]  = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);
        vecs[10] = mkVec(4'b0011, 4'b0001, 0, 0, 4'b0001, 1, 0, 0, 4'b0000, 0, 0, 0);
        vecs[11] = mkVec(4'b0011, 4'b0001, 0, 0, 4'b0001, 1, 0, 1, 4'b0001, 0, 0, 0);
        vecs[12] = mkVec(4'b0011, 4'b0001, 0, 0, 4'b0001, 1, 0, 2, 4'b0001, 0, 0, 0);
        vecs[13] = mkVec(4'b0011, 4'b0001, 0, 0, 4'b0001, 1, 0, 3, 4'b0001, 0, 0, 0);
        vecs[14] = mkVec(4'b0011, 4'b0001, 0, 0, 4'b0010, 1, 1, 0, 4'b0001, 0, 0, 1);
        vecs[15] = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0011, 1, 0, 1);
        vecs[16] = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0011, 1, 0, 1);
        vecs[17] = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0011, 1, 0, 1);
        vecs[18] = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0011, 1, 0, 1);
        vecs[19] = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0010, 1, 1, 0);
        vecs[20] = mkVec(4'b0100, 4'b0000, 0, 0, 4'b0100, 1, 2, 0, 4'b0000, 0, 0, 0);
        vecs[21] = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 0);
        vecs[22] = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 0);
        vecs[23] = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 0);
        vecs[24] = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0100, 0, 0, 1);
        vecs[25] = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0100, 1, 2, 0);
        vecs[26] = mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0);

        reset = 1'b1;
        applyStimulus(4'b1111, 4'b0000, 1'b0, 2'd0);
        #1;
        expectOutputs("in_reset", mkVec(4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));
        doReset();

        for (int i = 0; i < 27; i++) begin
            runStep($sformatf("table[%0d]", i), vecs[i]);
        end

        // Rollback of the owner at subcycle 2 squashes its in-flight entries.
        runStep("rb0", mkVec(4'b0011, 4'b0001, 0, 0, 4'b0001, 1, 0, 0, 4'b0000, 0, 0, 0));
        runStep("rb1", mkVec(4'b0011, 4'b0001, 0, 0, 4'b0001, 1, 0, 1, 4'b0001, 0, 0, 0));
        runStep("rb2", mkVec(4'b0011, 4'b0001, 1, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));
        runStep("rb3", mkVec(4'b0011, 4'b0001, 0, 0, 4'b0010, 1, 1, 0, 4'b0000, 0, 0, 0));
        runStep("rb4", mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0010, 0, 0, 0));
        runStep("rb5", mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0010, 0, 0, 0));
        runStep("rb6", mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0010, 0, 0, 0));
        runStep("rb7", mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0010, 0, 0, 1));
        runStep("rb8", mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0010, 1, 1, 0));

        // Reset in the middle of a sequence with three ops in flight.
        runStep("rst_e0", mkVec(4'b0001, 4'b0001, 0, 0, 4'b0001, 1, 0, 0, 4'b0000, 0, 0, 0));
        runStep("rst_e1", mkVec(4'b0001, 4'b0001, 0, 0, 4'b0001, 1, 0, 1, 4'b0001, 0, 0, 0));
        runStep("rst_e2", mkVec(4'b0001, 4'b0001, 0, 0, 4'b0001, 1, 0, 2, 4'b0001, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        expectOutputs("rst_e3", mkVec(4'b0001, 4'b0001, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(4'b1010, 4'b0000, 1'b0, 2'd0);
        #1;
        expectOutputs("rst_f0", mkVec(4'b1010, 4'b0000, 0, 0, 4'b0010, 1, 1, 0, 4'b0000, 0, 0, 0));
        runStep("rst_f1", mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0010, 0, 0, 0));
        runStep("rst_f2", mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0010, 0, 0, 0));
        runStep("rst_f3", mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0010, 0, 0, 0));
        runStep("rst_f4", mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0010, 0, 0, 1));
        runStep("rst_f5", mkVec(4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0010, 1, 1, 0));

        randomPhase(1500);

`ifdef FP_ISSUE_ARB_PERF_EN
        doReset();
        checkOutput("perf after reset", perf_contention, 32'd0);
        @(negedge clk);
        applyStimulus(4'b1111, 4'b0000, 1'b0, 2'd0);
        repeat (10) @(negedge clk);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 2'd0);
        #1;
        checkOutput("perf_contention", perf_contention, 32'd10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_issue_arbiter.md
Name: fp_issue_arbiter

Overview:
- Shares the multi-stage floating point pipeline (fp_execute_stage1..5) among NUM_REQUESTERS hardware threads using round-robin arbitration.
- Sequences multi-subcycle vector ops, issuing one subcycle per cycle and holding the grant until the last subcycle.
- Tracks every in-flight op through FP_LATENCY stages. This drives per-thread busy, FP writeback, rollback squash, and the integer-issue block that prevents writeback-port collisions.

Parameters:
NUM_REQUESTERS, 4, number of threads competing for the FP pipe (IDXW = $clog2(NUM_REQUESTERS))
FP_LATENCY, 5, cycles from issue to FP writeback
INT_LATENCY, 1, cycles from integer issue to integer writeback (must be < FP_LATENCY)
NUM_SUBCYCLES, 4, issue cycles for a multi-cycle op (SUBW = $clog2(NUM_SUBCYCLES))

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQUESTERS  requester r has an FP op ready
req_multi_cycle  in  NUM_REQUESTERS  op of r needs NUM_SUBCYCLES issue cycles (else 1)
rollback_en  in  1  squash the thread given by rollback_idx
rollback_idx  in  IDXW  thread being rolled back
grant_oh  out  NUM_REQUESTERS  one-hot grant this cycle (combinational)
fx_issue_valid  out  1  op/subcycle enters FP stage 1 this cycle
fx_issue_idx  out  IDXW  issuing thread
fx_issue_subcycle  out  SUBW  subcycle being issued
fx_inflight  out  NUM_REQUESTERS  thread has any valid op in tracker stages 1..FP_LATENCY
fp_wb_valid  out  1  FP result writes back this cycle
fp_wb_idx  out  IDXW  thread of writeback
int_issue_block  out  1  integer pipe must not issue this cycle

Behaviour:
- State: rr_ptr (IDXW), FSM {IDLE, SEQUENCE}, owner (IDXW), subcycle (SUBW), tracker stage[1..FP_LATENCY] = {valid, idx}.
- Reset: rr_ptr=0, IDLE, owner=0, subcycle=0, all stage valid=0. Therefore grant_oh=0, fx_issue_valid=0, fx_inflight=0, fp_wb_valid=0, int_issue_block=0. A reset mid-sequence drops the sequence; no partial state survives.
- Eligible(r) = req_valid[r] && !(rollback_en && rollback_idx==r).
- IDLE:
  - Grant the first eligible r scanning from rr_ptr upward with wrap; zero latency.
  - Outputs: fx_issue_valid=1, fx_issue_subcycle=0.
  - If req_multi_cycle[r] and NUM_SUBCYCLES>1: owner<=r, subcycle<=1, go to SEQUENCE.
  - Else: rr_ptr<=r+1 (mod NUM_REQUESTERS).
  - No eligible requester: no grant.
- SEQUENCE:
  - Grant only owner, regardless of req_valid. Other requests wait.
  - Outputs: fx_issue_subcycle=subcycle.
  - On subcycle==NUM_SUBCYCLES-1: rr_ptr<=owner+1, go to IDLE.
  - Otherwise: subcycle increments.
  - If rollback_en && rollback_idx==owner: no issue this cycle, go to IDLE, rr_ptr<=owner+1.
- Tracker:
  - Each cycle stage[k+1]<=stage[k]; stage[1]<={fx_issue_valid, fx_issue_idx}.
  - Rollback clears valid of every stage whose idx==rollback_idx in that same cycle's update.
- fp_wb_valid = stage[FP_LATENCY].valid && !(rollback_en && rollback_idx==stage[FP_LATENCY].idx); fp_wb_idx = stage[FP_LATENCY].idx.
- int_issue_block = stage[FP_LATENCY-INT_LATENCY].valid (post-rollback mask as above). An int op issued now would collide with that FP writeback.
- fx_inflight[r] = OR over k of (stage[k].valid && stage[k].idx==r), rollback-masked. Issue in the current cycle does not count.
- Simultaneous request and rollback of the same thread: not granted that cycle.
- rr_ptr wraps from NUM_REQUESTERS-1 to 0.
- Back-to-back issue is allowed every cycle; no bubbles between grants.

Optional Feature:
- Macro FP_ISSUE_ARB_PERF_EN.
- Defined: adds output perf_contention  out  32, a counter incrementing each cycle with at least one eligible requester not granted. Reset to 0, wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- After reset, req_valid=4'b0000 -> grant_oh=0, fx_issue_valid=0, int_issue_block=0; then req_valid=4'b1010 single-cycle -> grants thread 1, then 3, then 1, alternating each cycle.
- req_valid=4'b0011, req_multi_cycle[0]=1 -> thread 0 issues subcycles 0,1,2,3 on consecutive cycles, then thread 1 issues; fp_wb_valid for thread 0 on cycles 5..8 after the first issue.
- Single issue of thread 2 at cycle t -> int_issue_block=1 exactly at cycle t+4; fp_wb_valid=1, fp_wb_idx=2 at t+5; fx_inflight[2]=1 for t+1..t+5.
- Thread 0 multi-cycle at subcycle 2, rollback_en=1 with rollback_idx=0 -> no issue that cycle, FSM returns to IDLE, all thread-0 tracker entries cleared, no thread-0 writeback follows, thread 1 granted next if requesting.
- Assert reset during SEQUENCE with 3 ops in flight -> all outputs 0 immediately; the first request after reset is granted from rr_ptr=0.
- With FP_ISSUE_ARB_PERF_EN, req_valid=4'b1111 single-cycle for 10 cycles -> perf_contention=10.
